// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs
//   AXI4-Lite slave register bank. AW and W are captured independently and
//   committed together with byte strobes; one B response per write. Reads
//   return registered data one cycle after the AR handshake.
//
//   Optional build macro: AXIL_SLV_DECERR_EN
//     defined   -> address bits above the register index must be zero,
//                  otherwise writes are dropped / reads return 0, resp SLVERR.
//     undefined -> upper address bits ignored (aliasing), resp always OKAY.
//
// Ports
//   aclk, areset_n          clock, async active-low reset
//   awaddr/awvalid/awready  write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   bresp/bvalid/bready     write response channel
//   araddr/arvalid/arready  read address channel
//   rdata/rresp/rvalid/rready read data channel
//   regs_out                flat register bank, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
module axi_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                           aclk,
    input  logic                           areset_n,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [STRB_WIDTH-1:0]          wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    localparam int IDX_W   = $clog2(NUM_REGS);
    localparam int IDX_LSB = $clog2(STRB_WIDTH);

    typedef enum logic { W_COLLECT, W_RESP } w_state_t;
    typedef enum logic { R_IDLE,    R_RESP } r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

    logic                  aw_held;
    logic                  w_held;
    logic [IDX_W-1:0]      aw_idx_q;
    logic                  aw_oor_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;

    logic [IDX_W-1:0]      aw_idx;
    logic [IDX_W-1:0]      ar_idx;
    logic                  aw_oor;
    logic                  ar_oor;

    assign aw_idx = awaddr[IDX_LSB +: IDX_W];
    assign ar_idx = araddr[IDX_LSB +: IDX_W];

`ifdef AXIL_SLV_DECERR_EN
    assign aw_oor = |awaddr[ADDR_WIDTH-1:IDX_LSB+IDX_W];
    assign ar_oor = |araddr[ADDR_WIDTH-1:IDX_LSB+IDX_W];
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // Byte-offset bits (and upper bits when decode is off) are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr, araddr};

    assign awready  = (w_state == W_COLLECT) && !aw_held;
    assign wready   = (w_state == W_COLLECT) && !w_held;
    assign arready  = (r_state == R_IDLE);
    assign regs_out = regs;

    // Write path: flags persist across any AW/W gap; commit happens on the
    // edge after both are held, which is also when bvalid rises.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state  <= W_COLLECT;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            aw_oor_q <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
            regs     <= '0;
        end else begin
            case (w_state)
                W_COLLECT: begin
                    if (awvalid && awready) begin
                        aw_held  <= 1'b1;
                        aw_idx_q <= aw_idx;
                        aw_oor_q <= aw_oor;
                    end
                    if (wvalid && wready) begin
                        w_held   <= 1'b1;
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                    end
                    if (aw_held && w_held) begin
                        if (!aw_oor_q) begin
                            for (int b = 0; b < STRB_WIDTH; b++) begin
                                if (w_strb_q[b])
                                    regs[aw_idx_q][b*8 +: 8] <= w_data_q[b*8 +: 8];
                            end
                        end
                        bvalid  <= 1'b1;
                        bresp   <= aw_oor_q ? 2'b10 : 2'b00;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        w_state <= W_COLLECT;
                    end
                end
                default: w_state <= W_COLLECT;
            endcase
        end
    end

    // Read path: samples regs before any same-edge commit, so a colliding
    // read returns the pre-write value.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        rdata   <= ar_oor ? '0 : regs[ar_idx];
                        rresp   <= ar_oor ? 2'b10 : 2'b00;
                        rvalid  <= 1'b1;
                        r_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
module tb_axi_lite_slave_regs;

    logic         aclk;
    logic         areset_n;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [511:0] regs_out;

    axi_lite_slave_regs dut (
        .aclk(aclk), .areset_n(areset_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_out(regs_out)
    );

    typedef struct { logic [1:0] resp; int idx; logic [31:0] val; } b_exp_t;
    typedef struct { logic [1:0] resp; logic [31:0] data; } r_exp_t;

    b_exp_t      bq[$];
    r_exp_t      rq[$];
    logic [31:0] mdl [16];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          rdy_rand = 0;

    initial begin
        aclk = 0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout waiting for handshake", nm);
    endtask

    // Reference model: address decode from the bank geometry (16 x 32-bit).
    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic bit m_oor(input logic [31:0] a);
`ifdef AXIL_SLV_DECERR_EN
        return (a / 64) != 0;
`else
        return (a == 32'hFFFF_FFFF);
`endif
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = ($urandom_range(0, 15) * 4) + ($urandom & 3);
        if ($urandom_range(0, 7) == 0) a = a + (32'h100 << $urandom_range(0, 4));
        return a;
    endfunction

    // Commit the model write and queue the expected B response.
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        b_exp_t e;
        int idx;
        bit oor;
        idx = m_idx(addr);
        oor = m_oor(addr);
        if (!oor)
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
        e.resp = oor ? 2'b10 : 2'b00;
        e.idx  = idx;
        e.val  = mdl[idx];
        bq.push_back(e);
    endtask

    task automatic model_read(input logic [31:0] addr);
        r_exp_t e;
        bit oor;
        oor    = m_oor(addr);
        e.resp = oor ? 2'b10 : 2'b00;
        e.data = oor ? 32'h0 : mdl[m_idx(addr)];
        rq.push_back(e);
    endtask

    // Entered and left at posedge+1. Returns once bvalid should be high.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly);
        fork
            begin
                int n;
                repeat (aw_dly) begin @(posedge aclk); #1; end
                awaddr = addr; awvalid = 1;
                n = 0;
                @(negedge aclk);
                while (!awready && n < 50) begin @(negedge aclk); n++; end
                if (!awready) tmo("aw_handshake");
                @(posedge aclk); #1;
                awvalid = 0;
            end
            begin
                int n;
                repeat (w_dly) begin @(posedge aclk); #1; end
                wdata = data; wstrb = strb; wvalid = 1;
                n = 0;
                @(negedge aclk);
                while (!wready && n < 50) begin @(negedge aclk); n++; end
                if (!wready) tmo("w_handshake");
                @(posedge aclk); #1;
                wvalid = 0;
            end
        join
        chk("bvalid_before_commit", bvalid, 0);
        model_write(addr, data, strb);
        @(posedge aclk); #1;
        chk("bvalid_latency", bvalid, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly);
        int n;
        repeat (ar_dly) begin @(posedge aclk); #1; end
        araddr = addr; arvalid = 1;
        n = 0;
        @(negedge aclk);
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        if (!arready) tmo("ar_handshake");
        model_read(addr);
        @(posedge aclk); #1;
        arvalid = 0;
        chk("rvalid_latency", rvalid, 1);
    endtask

    task automatic wait_b_done();
        int n;
        n = 0;
        while (bvalid && n < 100) begin @(posedge aclk); #1; n++; end
        if (bvalid) tmo("b_done");
    endtask

    task automatic wait_r_done();
        int n;
        n = 0;
        while (rvalid && n < 100) begin @(posedge aclk); #1; n++; end
        if (rvalid) tmo("r_done");
    endtask

    // Random back-pressure on the response channels.
    initial begin
        forever begin
            @(posedge aclk); #1;
            if (rdy_rand) begin
                bready = ($urandom_range(0, 2) != 0);
                rready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor: compares each accepted response against the queued expectation.
    initial begin
        b_exp_t be;
        r_exp_t re;
        forever begin
            @(negedge aclk);
            if (areset_n) begin
                if (bvalid && bready) begin
                    if (bq.size() == 0) tmo("b_unexpected");
                    else begin
                        be = bq.pop_front();
                        chk("bresp", bresp, be.resp);
                        chk("regs_out", regs_out[be.idx*32 +: 32], be.val);
                    end
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) tmo("r_unexpected");
                    else begin
                        re = rq.pop_front();
                        chk("rdata", rdata, re.data);
                        chk("rresp", rresp, re.resp);
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] bresp_hold;
        r_exp_t     re;
        areset_n = 0;
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        araddr = 0; arvalid = 0; bready = 1; rready = 1;
        for (int i = 0; i < 16; i++) mdl[i] = 0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_regs", |regs_out, 0);
        @(negedge aclk) areset_n = 1;
        @(posedge aclk); #1;

        // Full word write, AW one cycle ahead of W, then read back.
        do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 1);
        wait_b_done();
        do_read(32'h8, 0);
        wait_r_done();

        // Partial strobes over the previous value -> DE22BE44.
        do_write(32'h8, 32'h11223344, 4'b0101, 0, 0);
        wait_b_done();
        do_read(32'h8, 0);
        wait_r_done();

        // W three cycles before AW; hold off B for four cycles.
        bready = 0;
        do_write(32'h14, 32'h0BADF00D, 4'hF, 3, 0);
        bresp_hold = bresp;
        repeat (4) begin
            @(posedge aclk); #1;
            chk("hold_awready", awready, 0);
            chk("hold_wready", wready, 0);
            chk("hold_bvalid", bvalid, 1);
            chk("hold_bresp", bresp, bresp_hold);
        end
        bready = 1;
        wait_b_done();
        chk("post_b_awready", awready, 1);
        chk("post_b_wready", wready, 1);

        // AR to reg 3 on the same edge the write to reg 3 commits.
        awaddr = 32'hC; awvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1;
        @(negedge aclk);
        chk("col_awready", awready, 1);
        chk("col_wready", wready, 1);
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0; araddr = 32'hC; arvalid = 1;
        @(negedge aclk);
        chk("col_arready", arready, 1);
        re.resp = 2'b00; re.data = 32'h0;
        rq.push_back(re);
        model_write(32'hC, 32'hA5A5A5A5, 4'hF);
        @(posedge aclk); #1;
        arvalid = 0;
        chk("col_bvalid", bvalid, 1);
        chk("col_rvalid", rvalid, 1);
        wait_b_done();
        wait_r_done();
        do_read(32'hC, 0);
        wait_r_done();

        // Address above the index field.
        do_write(32'h100, 32'h1, 4'hF, 0, 0);
        wait_b_done();
        do_read(32'h100, 0);
        wait_r_done();
        do_read(32'h0, 0);
        wait_r_done();

        // Randomized traffic with back-pressure.
        rdy_rand = 1;
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(rnd_addr(), $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3));
                wait_b_done();
            end else begin
                do_read(rnd_addr(), $urandom_range(0, 2));
                wait_r_done();
            end
        end
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), 0);
            wait_r_done();
        end
        rdy_rand = 0;
        @(posedge aclk); #1;

        // Reset while both responses are pending.
        bready = 0; rready = 0;
        do_write(32'h4, 32'h12345678, 4'hF, 0, 0);
        do_read(32'h4, 0);
        chk("pre_rst_bvalid", bvalid, 1);
        chk("pre_rst_rvalid", rvalid, 1);
        #2 areset_n = 0;
        #1;
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_regs", |regs_out, 0);
        bq.delete();
        rq.delete();
        for (int i = 0; i < 16; i++) mdl[i] = 0;
        bready = 1; rready = 1;
        @(negedge aclk) areset_n = 1;
        @(posedge aclk); #1;
        chk("rel_awready", awready, 1);
        chk("rel_wready", wready, 1);
        chk("rel_arready", arready, 1);
        chk("rel_regs", |regs_out, 0);
        do_read(32'h4, 0);
        wait_r_done();
        do_write(32'h3C, 32'hCAFEF00D, 4'b1100, 1, 0);
        wait_b_done();
        do_read(32'h3C, 0);
        wait_r_done();

        repeat (3) @(posedge aclk);
        if (bq.size() != 0 || rq.size() != 0) tmo("queues_not_drained");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
